// File: rtl/register_bank_sequencer_pkg.sv
// Shared opcode constants, sequencer state encoding and register-pair helpers
// for the register bank sequencer.
package reg_seq_pkg;

  localparam logic [2:0] OP_READ8   = 3'b000;
  localparam logic [2:0] OP_WRITE8  = 3'b001;
  localparam logic [2:0] OP_READ16  = 3'b010;
  localparam logic [2:0] OP_WRITE16 = 3'b011;
  localparam logic [2:0] OP_INC16   = 3'b100;
  localparam logic [2:0] OP_DEC16   = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_CAP, S_WHI, S_WLO, S_DONE
  } seqState_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  regIdx;
    logic [15:0] wdata;
  } seqReq_t;

  // Even register of a pair holds the high byte.
  function automatic logic [2:0] pairBase(input logic [2:0] r);
    return r & 3'b110;
  endfunction

  function automatic logic isWriteOp(input logic [2:0] op);
    return (op == OP_WRITE8) || (op == OP_WRITE16) || (op == OP_INC16) || (op == OP_DEC16);
  endfunction

endpackage

// File: rtl/register_bank_sequencer_if.sv
// Requester handshake and single-port bank bus of the register bank sequencer.
// master = requesters + bank side, slave = sequencer.
interface register_bank_sequencer_if;
  logic        req0, req1;
  logic [2:0]  op0, op1, reg0, reg1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata;
  logic        err;
  logic        busy;
  logic [2:0]  bankRegNum;
  logic        bankWriteEnable;
  logic [7:0]  bankDataIn;
  logic [7:0]  bankDataOut;
  logic [15:0] bankDataOut16;

  modport master (
    output req0, req1, op0, op1, reg0, reg1, wdata0, wdata1, bankDataOut, bankDataOut16,
    input  ack0, ack1, rdata, err, busy, bankRegNum, bankWriteEnable, bankDataIn
  );

  modport slave (
    input  req0, req1, op0, op1, reg0, reg1, wdata0, wdata1, bankDataOut, bankDataOut16,
    output ack0, ack1, rdata, err, busy, bankRegNum, bankWriteEnable, bankDataIn
  );
endinterface

// File: rtl/register_bank_sequencer_arbiter.sv
// Two-way grant for the sequencer: fixed priority (port 0) or round robin,
// evaluated only while the sequencer is idle.
module reg_seq_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic       grantVld,
  output logic       grantPort
);
  logic lastGrant;

  assign grantVld = enable && (req != 2'b00);

  always_comb begin
    if (req == 2'b11) grantPort = (ROUND_ROBIN != 0) ? !lastGrant : 1'b0;
    else              grantPort = req[1];
  end

  // Starts at 1 so port 0 takes the first contended grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        lastGrant <= 1'b1;
    else if (grantVld) lastGrant <= grantPort;
  end
endmodule

// File: rtl/register_bank_sequencer.sv
// Serializes 8/16-bit reads, writes and INC16/DEC16 from two requesters onto a
// single-port 8x8 register bank. Optional REG_SEQ_ZERO_FLAG_EN adds resultZero.
module register_bank_sequencer
  import reg_seq_pkg::*;
#(
  parameter int ROUND_ROBIN  = 1,
  parameter int ALLOW_WRITE1 = 1
) (
  input  logic clk,
  input  logic reset,
  register_bank_sequencer_if.slave bus
`ifdef REG_SEQ_ZERO_FLAG_EN
  , output logic resultZero
`endif
);
  seqState_t   state;
  logic [2:0]  curOp, curReg;
  logic        curPort;
  logic [15:0] rdataQ;
  logic        errQ;
  logic        grantVld, grantPort, illegal, forbid;
  seqReq_t     pick;
  logic [15:0] incDec;

  reg_seq_arbiter #(.ROUND_ROBIN(ROUND_ROBIN)) uArb (
    .clk(clk), .reset(reset), .req({bus.req1, bus.req0}), .enable(state == S_IDLE),
    .grantVld(grantVld), .grantPort(grantPort)
  );

  always_comb begin
    if (grantPort) begin
      pick.op = bus.op1; pick.regIdx = bus.reg1; pick.wdata = bus.wdata1;
    end else begin
      pick.op = bus.op0; pick.regIdx = bus.reg0; pick.wdata = bus.wdata0;
    end
  end

  assign illegal = (pick.op[2:1] == 2'b11);
  assign forbid  = grantPort && (ALLOW_WRITE1 == 0) && isWriteOp(pick.op);
  assign incDec  = (curOp == OP_INC16) ? bus.bankDataOut16 + 16'd1 : bus.bankDataOut16 - 16'd1;

  // rdataQ doubles as the write-data holder, so writes echo what went to the bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE; curOp <= '0; curReg <= '0; curPort <= 1'b0;
      rdataQ <= '0; errQ <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (grantVld) begin
          curOp <= pick.op; curReg <= pick.regIdx; curPort <= grantPort;
          errQ <= illegal || forbid; rdataQ <= '0;
          if (illegal || forbid)            state <= S_DONE;
          else if (pick.op == OP_WRITE8) begin
            rdataQ <= {8'h00, pick.wdata[7:0]}; state <= S_WLO;
          end else if (pick.op == OP_WRITE16) begin
            rdataQ <= pick.wdata; state <= S_WHI;
          end else                          state <= S_ADDR;
        end
        S_ADDR: state <= S_CAP;
        S_CAP: begin
          if (curOp == OP_READ8) begin
            rdataQ <= {8'h00, bus.bankDataOut}; state <= S_DONE;
          end else if (curOp == OP_READ16) begin
            rdataQ <= bus.bankDataOut16; state <= S_DONE;
          end else begin
            rdataQ <= incDec; state <= S_WHI;
          end
        end
        S_WHI:   state <= S_WLO;
        S_WLO:   state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack0  = (state == S_DONE) && !curPort;
  assign bus.ack1  = (state == S_DONE) && curPort;
  assign bus.err   = (state == S_DONE) && errQ;
  assign bus.rdata = rdataQ;
  assign bus.busy  = (state != S_IDLE);

  always_comb begin
    bus.bankRegNum = '0; bus.bankWriteEnable = 1'b0; bus.bankDataIn = '0;
    case (state)
      S_ADDR, S_CAP: bus.bankRegNum = (curOp == OP_READ8) ? curReg : pairBase(curReg);
      S_WHI: begin
        bus.bankWriteEnable = 1'b1;
        bus.bankRegNum      = pairBase(curReg);
        bus.bankDataIn      = rdataQ[15:8];
      end
      S_WLO: begin
        bus.bankWriteEnable = 1'b1;
        bus.bankRegNum      = (curOp == OP_WRITE8) ? curReg : (pairBase(curReg) | 3'b001);
        bus.bankDataIn      = rdataQ[7:0];
      end
      default: ;
    endcase
  end

`ifdef REG_SEQ_ZERO_FLAG_EN
  logic zeroFlag;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                zeroFlag <= 1'b0;
    else if (state == S_IDLE)  zeroFlag <= 1'b0;
    else if (state == S_CAP)   zeroFlag <= ((curOp == OP_INC16) || (curOp == OP_DEC16)) && (incDec == 16'h0000);
  end
  assign resultZero = zeroFlag && (state == S_DONE);
`endif
endmodule

// File: doc/register_bank_sequencer.md
Name: register_bank_sequencer

Overview:
- Sequences and arbitrates access to the CPU's 8 x 8-bit register bank.
- Bank is single-port: 3-bit regNum, 8-bit write, 8-bit read, 16-bit pair read; even index = high byte of its pair.
- Two requesters share the bank: port 0 is the instruction decoder, port 1 is the debug/host.
- Supports 8-bit read/write, 16-bit pair read/write, and INC16/DEC16 read-modify-write, serialized onto the bank.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate grant on contention; 0 = port 0 always wins.
- ALLOW_WRITE1, 1: 0 = port 1 is read-only; write/INC/DEC from port 1 completes with err, no bank write.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held high until ack0.
- op0  in  3  port 0 opcode.
- reg0  in  3  port 0 register index.
- wdata0  in  16  port 0 write data (8-bit ops use [7:0]).
- ack0  out  1  one-cycle completion pulse for port 0.
- req1, op1, reg1, wdata1, ack1: same as port 0, for port 1.
- rdata  out  16  result; valid while ack0/ack1 high; 8-bit reads zero-extended.
- err  out  1  valid with ack; illegal op or forbidden write.
- busy  out  1  high in any state other than IDLE.
- bankRegNum  out  3  to bank regNum.
- bankWriteEnable  out  1  to bank writeEnable.
- bankDataIn  out  8  to bank dataIn.
- bankDataOut  in  8  from bank dataOut; valid the cycle after bankRegNum is stable.
- bankDataOut16  in  16  from bank dataOut16; same timing.

Behaviour:
- Opcodes: 000 READ8, 001 WRITE8, 010 READ16, 011 WRITE16, 100 INC16, 101 DEC16, 11x illegal.
- 16-bit ops use pair base = reg & 3'b110; high byte goes to base, low byte to base|1.
- States: IDLE, ADDR, CAP, WHI, WLO, DONE.
- IDLE: at the clock edge, arbitrate and latch op/reg/wdata/port.
  - Next state: ADDR for reads and INC/DEC; WHI for WRITE16; WLO for WRITE8; DONE (err=1) for illegal or forbidden ops.
- ADDR: bankRegNum=reg (base for 16-bit ops), WE=0.
- CAP: same bankRegNum as ADDR.
  - Reads: latch rdata ({8'h00,bankDataOut} or bankDataOut16) -> DONE.
  - INC/DEC: latch bankDataOut16 +/- 1 mod 2^16 into rdata -> WHI.
- WHI: WE=1, bankRegNum=base, bankDataIn=rdata/wdata [15:8] -> WLO.
- WLO: WE=1, bankRegNum=base|1 (reg for WRITE8), bankDataIn=[7:0] -> DONE.
- DONE: ack of the latched port = 1 for one cycle, then IDLE.
  - Write ops echo the written value on rdata.
- Latency from latch edge to ack: READ8/READ16 3 cycles; WRITE8 2; WRITE16 3; INC/DEC 5; illegal 1.
- Handshake:
  - Requester drops req at the edge where it samples ack high.
  - req still high in IDLE is a new request.
  - op/reg/wdata are sampled only at the latch edge.
- Arbitration:
  - lastGrant resets to 1, so port 0 wins the first contention.
  - ROUND_ROBIN=1: on contention, grant !lastGrant.
  - A lone requester is always granted.
  - No grant is given outside IDLE.
- Bank outputs are decoded from state and latched fields; all are 0 in IDLE, DONE and reset.
- Reset values: ack0=ack1=0, rdata=0, err=0, busy=0, bank outputs 0, state IDLE.
- Reset mid-operation: immediate return to IDLE, no ack. A pair already written high-only stays half-written; no rollback.
- Wrap-around: INC16 of FFFF -> 0000; DEC16 of 0000 -> FFFF.

Optional Feature:
- REG_SEQ_ZERO_FLAG_EN defined: adds output resultZero (1 bit).
  - High with ack when op is INC16/DEC16 and the result is 0000; else 0; reset 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package reg_seq_pkg holds opcode constants, state encoding, and a pair-base function.
- One sub-module: reg_seq_arbiter, the 2-way fixed/round-robin grant with lastGrant register.

Test Plan:
- Preload bank DE AD BE EF BA BA BA BE; port0 READ16 reg=3 -> ack0 3 cycles after latch, rdata=BEEF, err=0.
- Port0 INC16 reg=4 on BABA -> bank writes BA to 4 then BB to 5, ack0 with rdata=BABB; pair 6/7 at FFFF -> rdata=0000 (resultZero=1 with macro).
- req0 and req1 both READ8 reg=0, each re-requesting twice -> grants 0,1,0,1 with ROUND_ROBIN=1; 0,0 then 1,1 with ROUND_ROBIN=0.
- ALLOW_WRITE1=0, port1 WRITE8 reg=2 data=55 -> ack1 next cycle, err=1, bankWriteEnable never high, register 2 stays BE.
- Op 110 on port0 -> ack0 after 1 cycle with err=1; busy high only during the DONE cycle.
- Assert reset low during WLO of WRITE16 1234 to pair 0 -> outputs 0 asynchronously, no ack, reg0=12 retained, reg1 unchanged (AD).
